// File: rtl/ysyx_25030093_mem_arbiter_if.sv
// Request/response bundle shared by the IFU, the LSU, the memory port and the arbiter.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface ysyx_25030093_mem_arbiter_if;
    logic        ifu_reqValid;
    logic [31:0] ifu_addr;
    logic        ifu_respValid;
    logic [31:0] ifu_rdata;

    logic        lsu_reqValid;
    logic [31:0] lsu_addr;
    logic [1:0]  lsu_size;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_respValid;
    logic [31:0] lsu_rdata;

    logic        mem_reqValid;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_respValid;
    logic [31:0] mem_rdata;

    logic        resp_err;

    modport master (
        input  ifu_reqValid, ifu_addr,
        output ifu_respValid, ifu_rdata,
        input  lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
        output lsu_respValid, lsu_rdata,
        output mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask,
        input  mem_respValid, mem_rdata,
        output resp_err
    );

    modport slave (
        output ifu_reqValid, ifu_addr,
        input  ifu_respValid, ifu_rdata,
        output lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
        input  lsu_respValid, lsu_rdata,
        input  mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask,
        output mem_respValid, mem_rdata,
        input  resp_err
    );
endinterface

// File: rtl/ysyx_25030093_mem_arbiter.sv
// IFU/LSU single-outstanding memory arbiter with a wait timeout.
// Define YSYX_25030093_ARB_RR_EN for round-robin; otherwise LSU has fixed priority.
module ysyx_25030093_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    ysyx_25030093_mem_arbiter_if.master bus
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IFU = 2'd1,
        BUSY_LSU = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] wait_cnt;
    logic          grant_any;
    logic          grant_lsu;
    logic          busy;
    logic          timeout;
    logic          done;

    logic [31:0]   addr_q;
    logic [1:0]    size_q;
    logic          wen_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wmask_q;

    assign busy      = state != IDLE;
    assign grant_any = !busy && (bus.ifu_reqValid || bus.lsu_reqValid);

    // A real response arriving on the timeout cycle takes precedence.
    assign timeout = busy && !bus.mem_respValid
                  && wait_cnt == CW'(TIMEOUT_CYCLES - 1);
    assign done    = busy && (bus.mem_respValid || timeout);

`ifdef YSYX_25030093_ARB_RR_EN
    logic last_lsu;

    assign grant_lsu = (bus.ifu_reqValid && bus.lsu_reqValid)
                     ? !last_lsu : bus.lsu_reqValid;

    always_ff @(posedge clock) begin
        if (!reset) begin
            last_lsu <= 1'b0;
        end else if (grant_any) begin
            last_lsu <= grant_lsu;
        end
    end
`else
    assign grant_lsu = bus.lsu_reqValid;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            addr_q   <= '0;
            size_q   <= '0;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
            wmask_q  <= '0;
        end else begin
            state <= state_nxt;
            if (grant_any) begin
                wait_cnt <= '0;
                if (grant_lsu) begin
                    addr_q  <= bus.lsu_addr;
                    size_q  <= bus.lsu_size;
                    wen_q   <= bus.lsu_wen;
                    wdata_q <= bus.lsu_wdata;
                    wmask_q <= bus.lsu_wmask;
                end else begin
                    addr_q  <= bus.ifu_addr;
                    size_q  <= 2'b10;
                    wen_q   <= 1'b0;
                    wdata_q <= '0;
                    wmask_q <= 4'b0000;
                end
            end else if (busy && !done) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (grant_any) begin
                    state_nxt = grant_lsu ? BUSY_LSU : BUSY_IFU;
                end
            end
            BUSY_IFU, BUSY_LSU: begin
                if (done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Responses are gated by reset so an abandoned transaction never answers.
    always_comb begin
        bus.ifu_respValid = 1'b0;
        bus.ifu_rdata     = '0;
        bus.lsu_respValid = 1'b0;
        bus.lsu_rdata     = '0;
        bus.resp_err      = reset && timeout;
        unique case (state)
            BUSY_IFU: begin
                bus.ifu_respValid = reset && done;
                bus.ifu_rdata     = timeout ? 32'hDEAD_BEEF : bus.mem_rdata;
            end
            BUSY_LSU: begin
                bus.lsu_respValid = reset && done;
                bus.lsu_rdata     = timeout ? 32'hDEAD_BEEF : bus.mem_rdata;
            end
            default: ;
        endcase
    end

    assign bus.mem_reqValid = busy;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_size     = size_q;
    assign bus.mem_wen      = wen_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.mem_wmask    = wmask_q;
endmodule

// File: tb/tb_ysyx_25030093_mem_arbiter.sv
// Directed bench for the memory arbiter: a transaction-level model checked every
// cycle, plus literal expectations for the reference scenarios.
module tb_ysyx_25030093_mem_arbiter;
    localparam int TMO = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;

    ysyx_25030093_mem_arbiter_if bus();

    ysyx_25030093_mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns memory, which busy cycle it is in.
    int          owner = 0;   // 0 none, 1 IFU, 2 LSU
    int          busy_n = 0;  // 1-based busy cycle index
    logic        last_lsu_m = 1'b0;
    logic        model_on = 1'b0;
    logic [31:0] e_addr, e_wdata;
    logic [1:0]  e_size;
    logic        e_wen;
    logic [3:0]  e_wmask;
    int          grants[$];

    always @(posedge clock) begin : model
        int pick;
        if (!reset) begin
            owner      = 0;
            last_lsu_m = 1'b0;
            model_on   = 1'b1;
        end else if (owner == 0) begin
            if (bus.ifu_reqValid || bus.lsu_reqValid) begin
                if (bus.ifu_reqValid && bus.lsu_reqValid) begin
`ifdef YSYX_25030093_ARB_RR_EN
                    pick = last_lsu_m ? 1 : 2;
`else
                    pick = 2;
`endif
                end else begin
                    pick = bus.lsu_reqValid ? 2 : 1;
                end
                if (pick == 1) begin
                    e_addr = bus.ifu_addr; e_size = 2'b10; e_wen = 1'b0;
                    e_wdata = 0; e_wmask = 4'b0;
                end else begin
                    e_addr = bus.lsu_addr; e_size = bus.lsu_size;
                    e_wen = bus.lsu_wen; e_wdata = bus.lsu_wdata;
                    e_wmask = bus.lsu_wmask;
                end
                owner      = pick;
                busy_n     = 1;
                last_lsu_m = (pick == 2);
                grants.push_back(pick);
            end
        end else if (bus.mem_respValid || busy_n == TMO) begin
            owner = 0;
        end else begin
            busy_n++;
        end
    end

    always @(negedge clock) begin : compare
        logic        tmo, fin;
        logic [31:0] rd;
        if (model_on) begin
            tmo = owner != 0 && busy_n == TMO && !bus.mem_respValid;
            fin = reset && owner != 0 && (bus.mem_respValid || tmo);
            rd  = tmo ? 32'hDEAD_BEEF : bus.mem_rdata;
            chk("m_reqValid", bus.mem_reqValid, owner != 0);
            chk("m_ifu_valid", bus.ifu_respValid, fin && owner == 1);
            chk("m_lsu_valid", bus.lsu_respValid, fin && owner == 2);
            chk("m_ifu_rdata", bus.ifu_rdata, owner == 1 ? rd : 0);
            chk("m_lsu_rdata", bus.lsu_rdata, owner == 2 ? rd : 0);
            chk("m_resp_err", bus.resp_err, reset && tmo);
            if (owner != 0) begin
                chk("m_addr", bus.mem_addr, e_addr);
                chk("m_size", bus.mem_size, e_size);
                chk("m_wen", bus.mem_wen, e_wen);
                chk("m_wdata", bus.mem_wdata, e_wdata);
                chk("m_wmask", bus.mem_wmask, e_wmask);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [31:0] exp_addr[4];
    int          exp_pick[4];
    int          seen;

    initial begin
        bus.ifu_reqValid = 0; bus.ifu_addr = 0;
        bus.lsu_reqValid = 0; bus.lsu_addr = 0; bus.lsu_size = 0;
        bus.lsu_wen = 0; bus.lsu_wdata = 0; bus.lsu_wmask = 0;
        bus.mem_respValid = 0; bus.mem_rdata = 0;

        // Reset state
        tick(); tick();
        @(negedge clock);
        chk("rst_reqValid", bus.mem_reqValid, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wmask", bus.mem_wmask, 0);
        chk("rst_size", bus.mem_size, 0);
        tick();
        reset = 1;

        // IFU fetch, answered on the 4th busy cycle
        bus.ifu_reqValid = 1; bus.ifu_addr = 32'h8000_0000;
        tick();
        @(negedge clock);
        chk("ifu_reqValid", bus.mem_reqValid, 1);
        chk("ifu_addr", bus.mem_addr, 32'h8000_0000);
        chk("ifu_wmask", bus.mem_wmask, 0);
        chk("ifu_size", bus.mem_size, 2'b10);
        tick(); tick(); tick();
        bus.mem_respValid = 1; bus.mem_rdata = 32'h0000_0413;
        @(negedge clock);
        chk("ifu_resp", bus.ifu_respValid, 1);
        chk("ifu_rdata", bus.ifu_rdata, 32'h0000_0413);
        tick();
        bus.mem_respValid = 0; bus.ifu_reqValid = 0;
        @(negedge clock);
        chk("ifu_idle", bus.mem_reqValid, 0);
        tick();

        // LSU byte store; inputs scrambled while busy
        bus.lsu_reqValid = 1; bus.lsu_addr = 32'h8000_0003; bus.lsu_size = 0;
        bus.lsu_wen = 1; bus.lsu_wdata = 32'hAB; bus.lsu_wmask = 4'b1000;
        tick();
        bus.lsu_addr = 32'h1234_5678; bus.lsu_wdata = 32'hFFFF;
        bus.lsu_wmask = 4'b0001; bus.lsu_size = 2;
        @(negedge clock);
        chk("sb_addr", bus.mem_addr, 32'h8000_0003);
        chk("sb_wmask", bus.mem_wmask, 4'b1000);
        chk("sb_wdata", bus.mem_wdata, 32'hAB);
        chk("sb_wen", bus.mem_wen, 1);
        tick();
        bus.mem_respValid = 1; bus.mem_rdata = 32'h55;
        @(negedge clock);
        chk("sb_lsu_resp", bus.lsu_respValid, 1);
        chk("sb_ifu_resp", bus.ifu_respValid, 0);
        chk("sb_addr_hold", bus.mem_addr, 32'h8000_0003);
        tick();
        bus.mem_respValid = 0; bus.lsu_reqValid = 0;

        // Both requesting continuously from a fresh reset
        reset = 0; tick(); tick(); reset = 1;
        grants.delete();
`ifdef YSYX_25030093_ARB_RR_EN
        exp_addr = '{32'h2000, 32'h1000, 32'h2000, 32'h1000};
        exp_pick = '{2, 1, 2, 1};
`else
        exp_addr = '{32'h2000, 32'h2000, 32'h2000, 32'h2000};
        exp_pick = '{2, 2, 2, 2};
`endif
        bus.ifu_reqValid = 1; bus.ifu_addr = 32'h1000;
        bus.lsu_reqValid = 1; bus.lsu_addr = 32'h2000; bus.lsu_wen = 0;
        bus.lsu_size = 2; bus.lsu_wmask = 0; bus.lsu_wdata = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.mem_respValid = 1; bus.mem_rdata = 32'h100 + i;
            @(negedge clock);
            chk("arb_addr", bus.mem_addr, exp_addr[i]);
            tick();
            bus.mem_respValid = 0;
        end
        bus.ifu_reqValid = 0; bus.lsu_reqValid = 0;
        chk("arb_count", grants.size(), 4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            chk("arb_model", grants[i], exp_pick[i]);
        tick();

        // Timeout with no response, then a late response in IDLE
        bus.lsu_reqValid = 1; bus.lsu_addr = 32'h3000;
        tick();
        seen = 0;
        for (int c = 1; c <= 20 && seen == 0; c++) begin
            @(negedge clock);
            if (bus.lsu_respValid) begin
                seen = c;
                chk("tmo_rdata", bus.lsu_rdata, 32'hDEAD_BEEF);
                chk("tmo_err", bus.resp_err, 1);
            end
            tick();
        end
        chk("tmo_cycle", seen, TMO);
        bus.lsu_reqValid = 0;
        bus.mem_respValid = 1; bus.mem_rdata = 32'h9999;
        @(negedge clock);
        chk("late_lsu", bus.lsu_respValid, 0);
        chk("late_ifu", bus.ifu_respValid, 0);
        chk("late_err", bus.resp_err, 0);
        tick();
        bus.mem_respValid = 0;
        tick();

        // Response on the timeout cycle wins
        bus.lsu_reqValid = 1; bus.lsu_addr = 32'h5000;
        tick();
        repeat (TMO - 1) tick();
        bus.mem_respValid = 1; bus.mem_rdata = 32'h77;
        @(negedge clock);
        chk("race_resp", bus.lsu_respValid, 1);
        chk("race_rdata", bus.lsu_rdata, 32'h77);
        chk("race_err", bus.resp_err, 0);
        tick();
        bus.mem_respValid = 0; bus.lsu_reqValid = 0;
        tick();

        // Reset mid-wait abandons the LSU; pending IFU granted afterwards
        bus.lsu_reqValid = 1; bus.lsu_addr = 32'h6000;
        tick();
        bus.ifu_reqValid = 1; bus.ifu_addr = 32'h4000;
        tick(); tick();
        reset = 0; bus.mem_respValid = 1; bus.mem_rdata = 32'h11;
        @(negedge clock);
        chk("rst_mid_resp", bus.lsu_respValid, 0);
        tick();
        reset = 1; bus.lsu_reqValid = 0; bus.mem_respValid = 0;
        @(negedge clock);
        chk("rst_mid_idle", bus.mem_reqValid, 0);
        chk("rst_mid_resp2", bus.lsu_respValid, 0);
        tick();
        @(negedge clock);
        chk("rst_ifu_grant", bus.mem_reqValid, 1);
        chk("rst_ifu_addr", bus.mem_addr, 32'h4000);
        tick();
        bus.mem_respValid = 1; bus.mem_rdata = 32'h22;
        @(negedge clock);
        chk("rst_ifu_resp", bus.ifu_respValid, 1);
        tick();
        bus.mem_respValid = 0; bus.ifu_reqValid = 0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_25030093_mem_arbiter.md
YSYX_25030093_MEM_ARBITER -- requirements
Module: ysyx_25030093_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, cycles a granted transaction may wait for mem_respValid before forced error completion (legal range 2..65535).
REQ-002 SHALL have ports: clock  input  1  system clock, all state on rising edge.
REQ-003 SHALL have ports: reset  input  1  synchronous, active-low reset; reset==0 sampled at a clock edge resets the block.
REQ-004 SHALL have IFU ports: ifu_reqValid in 1; ifu_addr in 32; ifu_respValid out 1; ifu_rdata out 32.
REQ-005 SHALL have LSU ports: lsu_reqValid in 1; lsu_addr in 32; lsu_size in 2; lsu_wen in 1; lsu_wdata in 32; lsu_wmask in 4; lsu_respValid out 1; lsu_rdata out 32.
REQ-006 SHALL have memory ports: mem_reqValid out 1; mem_addr out 32; mem_size out 2; mem_wen out 1; mem_wdata out 32; mem_wmask out 4; mem_respValid in 1; mem_rdata in 32.
REQ-007 SHALL have resp_err out 1: one-cycle pulse coinciding with a timeout-forced response.

Function
REQ-008 SHALL implement states IDLE, BUSY_IFU, BUSY_LSU; exactly one memory transaction in flight.
REQ-009 IDLE: on an edge with any reqValid high, SHALL select one requester, register its request fields into mem_* outputs and enter BUSY_IFU/BUSY_LSU; grant latency one cycle.
REQ-010 IFU grant SHALL drive mem_size=2'b10, mem_wen=0, mem_wdata=0, mem_wmask=4'b0000, mem_addr=ifu_addr.
REQ-011 LSU grant SHALL copy lsu_addr/size/wen/wdata/wmask unchanged to mem_*.
REQ-012 mem_reqValid SHALL be 1 in both BUSY states, including the cycle mem_respValid arrives, and 0 in IDLE.
REQ-013 mem_* request fields SHALL stay stable throughout BUSY regardless of requester input changes.
REQ-014 In BUSY_x, x_respValid SHALL equal mem_respValid combinationally and x_rdata SHALL equal mem_rdata; the non-granted requester sees respValid=0, rdata=0.
REQ-015 Edge with mem_respValid=1 in BUSY SHALL return to IDLE; a new grant occurs at the earliest one cycle later (one IDLE cycle between transactions).
REQ-016 Requesters hold reqValid until their respValid; a reqValid dropped while not granted SHALL simply not be granted.
REQ-017 Wait counter SHALL clear on grant and increment each BUSY cycle without mem_respValid; when it reaches TIMEOUT_CYCLES-1, SHALL assert granted x_respValid=1, x_rdata=32'hDEAD_BEEF, resp_err=1 for that cycle and return to IDLE.
REQ-018 mem_respValid arriving in the same cycle as timeout SHALL win: normal response, resp_err=0.
REQ-019 mem_respValid in IDLE (late response after timeout) SHALL be ignored; no respValid to either requester.
REQ-020 Counter SHALL be $clog2(TIMEOUT_CYCLES)+1 bits and never wrap.

Reset
REQ-021 reset==0 at an edge SHALL force IDLE, counter=0, mem_reqValid=0, mem_addr=0, mem_size=0, mem_wen=0, mem_wdata=0, mem_wmask=0, last-grant=IFU.
REQ-022 While in reset and the cycle after, ifu_respValid, lsu_respValid, resp_err SHALL be 0; reset mid-transaction SHALL abandon it with no response.

Configuration
REQ-023 Macro YSYX_25030093_ARB_RR_EN defined: simultaneous requests in IDLE SHALL grant the requester not granted last (round-robin, last-grant register updated at each grant).
REQ-024 Macro undefined: simultaneous requests SHALL always grant LSU (fixed priority); last-grant register absent.

Verification
REQ-025 IFU only, ifu_addr=0x8000_0000, mem_respValid after 3 BUSY cycles with mem_rdata=0x0000_0413 -> mem_reqValid 1 cycle after request, mem_wmask=0, ifu_respValid=1 with rdata 0x0000_0413, IDLE next cycle.
REQ-026 LSU sb, lsu_addr=0x8000_0003, wmask=4'b1000, wdata=0xAB -> mem_* match inputs, lsu_respValid on mem_respValid, ifu_respValid stays 0.
REQ-027 Both requesting continuously, 4 transactions -> fixed build: LSU,LSU,LSU,LSU; RR build: LSU,IFU,LSU,IFU (after reset last-grant=IFU).
REQ-028 TIMEOUT_CYCLES=8, no mem_respValid -> on 8th BUSY cycle lsu_respValid=1, rdata=0xDEAD_BEEF, resp_err=1; late mem_respValid in IDLE produces no response.
REQ-029 reset=0 asserted in BUSY_LSU mid-wait -> next cycle IDLE, mem_reqValid=0, no respValid; pending IFU granted after reset released.
